// File: rtl/dcache_pkg.sv
// dcache_pkg: shared definitions for the direct-mapped write-through data cache.
//   NLINES_DEFAULT : default number of one-word lines
//   state_t        : controller states (IDLE, RMISS, WMEM)
package dcache_pkg;

  localparam int NLINES_DEFAULT = 16;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    RMISS = 2'd1,
    WMEM  = 2'd2
  } state_t;

endpackage

// File: rtl/dcache_if.sv
// dcache_if: backing-memory bus bundle between the cache and a memory.
//
// Handshake: the master raises mem_req and holds mem_req, mem_we, mem_addr and
// mem_wdata stable until the slave answers with a single-cycle mem_ack. On a
// read, mem_rdata is valid only in the mem_ack cycle. mem_req drops in the
// cycle after mem_ack; an ack with no request outstanding carries no meaning.
//
// Modports:
//   master : cache side  (drives mem_req/mem_we/mem_addr/mem_wdata)
//   slave  : memory side (drives mem_rdata/mem_ack)
interface dcache_if;

  logic        mem_req;
  logic        mem_we;
  logic [31:0] mem_addr;
  logic [31:0] mem_wdata;
  logic [31:0] mem_rdata;
  logic        mem_ack;

  modport master (
    output mem_req, mem_we, mem_addr, mem_wdata,
    input  mem_rdata, mem_ack
  );

  modport slave (
    input  mem_req, mem_we, mem_addr, mem_wdata,
    output mem_rdata, mem_ack
  );

endinterface

// File: rtl/dcache_array.sv
// dcache_array: valid/tag/data storage for the direct-mapped cache.
//   clk, reset        : clock, synchronous active-high reset (clears valid only)
//   ridx              : combinational read index
//   rvalid/rtag/rdata : contents of line ridx
//   we/widx/wtag/wdata: single synchronous write port; a write also sets valid
module dcache_array #(
  parameter int NLINES = 16,
  parameter int TAGW   = 26
) (
  input  logic                      clk,
  input  logic                      reset,
  input  logic [$clog2(NLINES)-1:0] ridx,
  output logic                      rvalid,
  output logic [TAGW-1:0]           rtag,
  output logic [31:0]               rdata,
  input  logic                      we,
  input  logic [$clog2(NLINES)-1:0] widx,
  input  logic [TAGW-1:0]           wtag,
  input  logic [31:0]               wdata
);

  logic [NLINES-1:0] valid;
  logic [TAGW-1:0]   tags  [NLINES];
  logic [31:0]       data  [NLINES];

  always_ff @(posedge clk) begin
    if (reset) begin
      valid <= '0;
    end else if (we) begin
      valid[widx] <= 1'b1;
    end
  end

  // Tag and data contents are meaningless until valid is set, so no reset.
  always_ff @(posedge clk) begin
    if (we) begin
      tags[widx] <= wtag;
      data[widx] <= wdata;
    end
  end

  assign rvalid = valid[ridx];
  assign rtag   = tags[ridx];
  assign rdata  = data[ridx];

endmodule

// File: rtl/dcache.sv
// dcache: direct-mapped, one-word-per-line, write-through, no-write-allocate
// data cache sitting in the M stage of a pipeline.
//   clk, reset              : clock, synchronous active-high reset
//   cpu_re/cpu_we           : load/store present in M (store wins if both)
//   cpu_addr/cpu_wdata      : byte address (bits [1:0] ignored), store data
//   cpu_rdata               : load data, meaningful only on a read hit
//   cpu_stall               : holds the pipeline while the access is pending
//   mem_req/mem_we/mem_addr/mem_wdata/mem_rdata/mem_ack : backing-memory bus
//   fsm_state               : controller state, for observation
module dcache
  import dcache_pkg::*;
#(
  parameter int NLINES = NLINES_DEFAULT,
  parameter int TAGW   = 30 - $clog2(NLINES)
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        cpu_re,
  input  logic        cpu_we,
  input  logic [31:0] cpu_addr,
  input  logic [31:0] cpu_wdata,
  output logic [31:0] cpu_rdata,
  output logic        cpu_stall,
  output logic        mem_req,
  output logic        mem_we,
  output logic [31:0] mem_addr,
  output logic [31:0] mem_wdata,
  input  logic [31:0] mem_rdata,
  input  logic        mem_ack,
  output state_t      fsm_state
);

  localparam int IDXW = $clog2(NLINES);

  state_t      state;
  logic [31:0] addr_q;
  logic [31:0] wdata_q;

  // While a transaction is open the CPU address is held by the stall, but the
  // latched copy is the one the memory sees, so lookups use it outside IDLE.
  logic [31:0]     raddr;
  logic [IDXW-1:0] idx;
  logic [TAGW-1:0] tag;
  logic            raddr_lsb_unused;

  assign raddr            = (state == IDLE) ? cpu_addr : addr_q;
  assign idx              = raddr[IDXW+1:2];
  assign tag              = raddr[31:IDXW+2];
  assign raddr_lsb_unused = ^raddr[1:0];

  logic            rd_valid;
  logic [TAGW-1:0] rd_tag;
  logic [31:0]     rd_data;
  logic            hit;
  logic            arr_we;
  logic [31:0]     arr_wdata;

  assign hit = rd_valid & (rd_tag == tag);

  // Fill on read-miss completion; on store completion update only a resident
  // line (write-through, no allocate). Reset abandons any completing fill.
  assign arr_we    = ~reset & mem_ack &
                     ((state == RMISS) | ((state == WMEM) & hit));
  assign arr_wdata = (state == RMISS) ? mem_rdata : wdata_q;

  dcache_array #(
    .NLINES (NLINES),
    .TAGW   (TAGW)
  ) u_array (
    .clk    (clk),
    .reset  (reset),
    .ridx   (idx),
    .rvalid (rd_valid),
    .rtag   (rd_tag),
    .rdata  (rd_data),
    .we     (arr_we),
    .widx   (idx),
    .wtag   (tag),
    .wdata  (arr_wdata)
  );

  // Controller: state and memory-bus outputs are all registered, so mem_req
  // has no combinational path from the CPU side.
  always_ff @(posedge clk) begin
    if (reset) begin
      state   <= IDLE;
      mem_req <= 1'b0;
      mem_we  <= 1'b0;
      addr_q  <= '0;
      wdata_q <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (cpu_we) begin
            state   <= WMEM;
            mem_req <= 1'b1;
            mem_we  <= 1'b1;
            addr_q  <= cpu_addr;
            wdata_q <= cpu_wdata;
          end else if (cpu_re && !hit) begin
            state   <= RMISS;
            mem_req <= 1'b1;
            mem_we  <= 1'b0;
            addr_q  <= cpu_addr;
          end
        end
        RMISS, WMEM: begin
          if (mem_ack) begin
            state   <= IDLE;
            mem_req <= 1'b0;
            mem_we  <= 1'b0;
          end
        end
        default: begin
          state   <= IDLE;
          mem_req <= 1'b0;
          mem_we  <= 1'b0;
        end
      endcase
    end
  end

  assign mem_addr  = {addr_q[31:2], 2'b00};
  assign mem_wdata = wdata_q;
  assign cpu_rdata = rd_data;
  assign fsm_state = state;

  // A read miss must stall in the very cycle it is detected; a store releases
  // the pipeline in its ack cycle since nothing comes back to the CPU.
  always_comb begin
    cpu_stall = 1'b0;
    case (state)
      IDLE:    cpu_stall = cpu_we | (cpu_re & ~hit);
      RMISS:   cpu_stall = 1'b1;
      WMEM:    cpu_stall = ~mem_ack;
      default: cpu_stall = 1'b0;
    endcase
  end

endmodule

// File: tb/tb_dcache.sv
// tb_dcache: directed and randomized checks of dcache against a line-level
// reference model (which words are resident) and a golden backing memory.
module tb_dcache;
  import dcache_pkg::*;

  localparam int NL = 16;

  // ---------------- clock / reset ----------------
  logic        clk = 1'b0;
  logic        reset;
  logic        cpu_re, cpu_we;
  logic [31:0] cpu_addr, cpu_wdata, cpu_rdata;
  logic        cpu_stall;
  state_t      fsm_state;

  dcache_if mem_bus ();

  dcache #(.NLINES(NL), .TAGW(26)) dut (
    .clk       (clk),
    .reset     (reset),
    .cpu_re    (cpu_re),
    .cpu_we    (cpu_we),
    .cpu_addr  (cpu_addr),
    .cpu_wdata (cpu_wdata),
    .cpu_rdata (cpu_rdata),
    .cpu_stall (cpu_stall),
    .mem_req   (mem_bus.mem_req),
    .mem_we    (mem_bus.mem_we),
    .mem_addr  (mem_bus.mem_addr),
    .mem_wdata (mem_bus.mem_wdata),
    .mem_rdata (mem_bus.mem_rdata),
    .mem_ack   (mem_bus.mem_ack),
    .fsm_state (fsm_state)
  );

  always #5 clk = ~clk;

  // ---------------- scoreboard / model state ----------------
  int tests = 0;
  int fails = 0;
  logic [31:0] exp_q[$];
  logic [31:0] bmem [logic [31:0]];   // golden backing memory, by word address
  bit          m_valid [NL];          // model: line holds a word
  logic [31:0] m_word  [NL];          // model: which word address it holds
  int          mem_lat;
  int          wait_cnt;

  function automatic logic [31:0] mem_word(input logic [31:0] w);
    if (bmem.exists(w)) return bmem[w];
    return (w * 32'h9E37_79B9) ^ 32'h1234_5678;
  endfunction

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // ---------------- driver tasks ----------------
  task automatic tick();
    @(posedge clk);
    @(negedge clk);
  endtask

  // Memory responder: acks on the mem_lat-th cycle that mem_req is seen high.
  task automatic mem_model();
    mem_bus.mem_ack = 1'b0;
    if (mem_bus.mem_req === 1'b1) begin
      wait_cnt++;
      if (wait_cnt >= mem_lat) begin
        wait_cnt        = 0;
        mem_bus.mem_ack = 1'b1;
        if (mem_bus.mem_we) bmem[mem_bus.mem_addr >> 2] = mem_bus.mem_wdata;
        else mem_bus.mem_rdata = mem_word(mem_bus.mem_addr >> 2);
      end
    end else begin
      wait_cnt = 0;
    end
  endtask

  task automatic clear_model();
    for (int i = 0; i < NL; i++) m_valid[i] = 1'b0;
    exp_q.delete();
  endtask

  task automatic do_reset();
    reset = 1'b1;
    cpu_re = 1'b0; cpu_we = 1'b0; cpu_addr = '0; cpu_wdata = '0;
    mem_bus.mem_ack = 1'b0; mem_bus.mem_rdata = '0;
    wait_cnt = 0;
    tick();
    tick();
    reset = 1'b0;
    #1;
    check("reset cpu_stall", {31'b0, cpu_stall}, 32'd0);
    check("reset mem_req", {31'b0, mem_bus.mem_req}, 32'd0);
    check("reset mem_we", {31'b0, mem_bus.mem_we}, 32'd0);
    check("reset state", {30'b0, fsm_state}, {30'b0, IDLE});
    clear_model();
  endtask

  // One CPU access held until the stall drops; checks stall/request counts,
  // bus contents on every request cycle, and load data.
  task automatic do_access(input bit we, input bit re, input logic [31:0] addr,
                           input logic [31:0] wdata, input int lat, input string tag);
    logic [31:0] word;
    int idx, exp_stall, exp_req, n_stall, n_req;
    bit hit, is_store, done;
    word     = addr >> 2;
    idx      = int'(word % NL);
    hit      = m_valid[idx] && (m_word[idx] == word);
    is_store = we;
    if (is_store) begin
      exp_stall = lat; exp_req = lat;
    end else begin
      exp_stall = hit ? 0 : lat + 1;
      exp_req   = hit ? 0 : lat;
      exp_q.push_back(mem_word(word));
    end
    mem_lat = lat;
    cpu_we = we; cpu_re = re; cpu_addr = addr; cpu_wdata = wdata;
    n_stall = 0; n_req = 0; done = 1'b0;
    for (int cyc = 0; cyc < 40 && !done; cyc++) begin
      mem_model();
      #1;
      if (mem_bus.mem_req === 1'b1) begin
        n_req++;
        check({tag, " mem_addr"}, mem_bus.mem_addr, addr & ~32'h3);
        check({tag, " mem_we"}, {31'b0, mem_bus.mem_we}, {31'b0, is_store});
        if (is_store) check({tag, " mem_wdata"}, mem_bus.mem_wdata, wdata);
      end
      if (cpu_stall === 1'b0) begin
        done = 1'b1;
        if (!is_store && exp_q.size() > 0) check({tag, " rdata"}, cpu_rdata, exp_q.pop_front());
      end else begin
        n_stall++;
      end
      tick();
    end
    check({tag, " completed"}, {31'b0, done}, 32'd1);
    check({tag, " stall cycles"}, n_stall, exp_stall);
    check({tag, " req cycles"}, n_req, exp_req);
    cpu_re = 1'b0; cpu_we = 1'b0;
    exp_q.delete();
    if (!is_store && !hit) begin
      m_valid[idx] = 1'b1;
      m_word[idx]  = word;
    end
  endtask

  // ---------------- stimulus ----------------
  initial begin
    logic [31:0] a;
    int op;
    do_reset();

    // Cold load, re-hit, store-no-allocate, store-hit update
    bmem[32'h50 >> 2] = 32'h7;
    do_access(1'b0, 1'b1, 32'h50, 32'h0, 3, "cold load 0x50");
    do_access(1'b0, 1'b1, 32'h50, 32'h0, 3, "hit load 0x50");
    do_access(1'b1, 1'b0, 32'h54, 32'h7, 1, "store 0x54");
    do_access(1'b0, 1'b1, 32'h54, 32'h0, 2, "load 0x54 after store");
    do_access(1'b1, 1'b0, 32'h50, 32'hAB, 2, "store 0xAB to 0x50");
    do_access(1'b0, 1'b1, 32'h50, 32'h0, 2, "load 0x50 after store");
    check("0x50 holds 0xAB in memory", mem_word(32'h50 >> 2), 32'hAB);

    // Conflict eviction on a shared index
    do_access(1'b0, 1'b1, 32'h10, 32'h0, 2, "load 0x10");
    do_access(1'b0, 1'b1, 32'h50, 32'h0, 2, "load 0x50 evicts");
    do_access(1'b0, 1'b1, 32'h10, 32'h0, 2, "reload 0x10");

    // Reset on the second cycle of a read miss, then a stray ack in IDLE
    mem_lat = 5;
    cpu_re = 1'b1; cpu_we = 1'b0; cpu_addr = 32'h200;
    mem_model(); #1;
    check("rst-miss detect stall", {31'b0, cpu_stall}, 32'd1);
    tick();
    mem_model(); #1;
    check("rst-miss req cycle1", {31'b0, mem_bus.mem_req}, 32'd1);
    tick();
    reset = 1'b1;
    mem_model(); #1;
    check("rst-miss req cycle2", {31'b0, mem_bus.mem_req}, 32'd1);
    tick();
    reset = 1'b0; cpu_re = 1'b0;
    mem_bus.mem_ack = 1'b1; mem_bus.mem_rdata = 32'hDEAD_BEEF;
    #1;
    check("rst-miss req dropped", {31'b0, mem_bus.mem_req}, 32'd0);
    check("stray ack stall", {31'b0, cpu_stall}, 32'd0);
    tick();
    mem_bus.mem_ack = 1'b0; wait_cnt = 0;
    #1;
    check("stray ack no req", {31'b0, mem_bus.mem_req}, 32'd0);
    clear_model();
    do_access(1'b0, 1'b1, 32'h200, 32'h0, 2, "load after abandoned miss");

    // Randomized mix over 64 words (4 tags per index) with random latency
    for (int n = 0; n < 80; n++) begin
      a  = ($urandom_range(0, 63) << 2) | $urandom_range(0, 3);
      op = $urandom_range(0, 9);
      if (op < 6)      do_access(1'b0, 1'b1, a, 32'h0, $urandom_range(1, 4), "rand load");
      else if (op < 9) do_access(1'b1, 1'b0, a, $urandom, $urandom_range(1, 4), "rand store");
      else             do_access(1'b1, 1'b1, a, $urandom, $urandom_range(1, 4), "rand load+store");
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not complete");
    $fatal(1, "watchdog");
  end

endmodule
